// File: rtl/multibyte_add_seq.sv
// Wide unsigned adder built by stepping one shared 8-bit adder across the
// operand bytes, LSB first, with the inter-byte carry held in a register.

module eight_bit_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       ci_i,
    output logic [7:0] so_o,
    output logic       co_o
);
    // Single byte of ripple addition; the only adder in the sequencer.
    always_comb begin
        {co_o, so_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, ci_i};
    end
endmodule

module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                ci,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                co
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    part_q;
    logic [W-1:0]    sum_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic            co_q;
    logic            busy_q;
    logic            done_q;

    logic [7:0]      a_byte_s;
    logic [7:0]      b_byte_s;
    logic [7:0]      add_so_s;
    logic            add_co_s;
    logic [W-1:0]    part_d;
    logic            accept_s;

    // Operand byte select for the shared adder and the partial result with
    // the current byte merged in (this becomes sum on the final byte).
    always_comb begin
        a_byte_s = a_q[8*int'(idx_q) +: 8];
        b_byte_s = b_q[8*int'(idx_q) +: 8];
        part_d   = part_q;
        part_d[8*int'(idx_q) +: 8] = add_so_s;
        accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    eight_bit_adder u_adder (
        .a_i  (a_byte_s),
        .b_i  (b_byte_s),
        .ci_i (carry_q),
        .so_o (add_so_s),
        .co_o (add_co_s)
    );

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (accept_s) begin
            // Same acceptance from IDLE or DONE, which gives back-to-back adds.
            a_q     <= a;
            b_q     <= b;
            carry_q <= ci;
            part_q  <= '0;
            idx_q   <= '0;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                ST_RUN: begin
                    part_q  <= part_d;
                    carry_q <= add_co_s;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= part_d;
                        co_q    <= add_co_s;
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq (NBYTES=4): stimulus pushes expected
// {co,sum}; a monitor pops and compares on every done pulse.

module tb_multibyte_add_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        co;

    logic [32:0] sb_q[$];
    int n_vec;
    int n_miss;

    multibyte_add_seq #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check("sum", 64'(sum), 64'(e[31:0]));
                check("co", 64'(co), 64'(e[32]));
            end
        end
    end

    // Issue one add, scramble operands while it runs, count busy cycles.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic civ,
                          input logic [31:0] exp_sum, input logic exp_co, input string tag);
        int busy_cnt;
        logic got;
        @(negedge clk);
        a = av; b = bv; ci = civ; start = 1'b1;
        sb_q.push_back({exp_co, exp_sum});
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                a = $urandom; b = $urandom; ci = 1'($urandom);
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;

        // Reset held: random activity must not disturb outputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom); a = $urandom; b = $urandom; ci = 1'($urandom);
            @(negedge clk);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_sum", 64'(sum), 64'd0);
            check("rst_co", 64'(co), 64'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rel_busy", 64'(busy), 64'd0);
        check("rel_done", 64'(done), 64'd0);
        check("rel_sum", 64'(sum), 64'd0);
        check("rel_co", 64'(co), 64'd0);

        run_op(32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0, "simple");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "ripple");
        run_op(32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, "cin1");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, "cin2");
        check("hold_sum", 64'(sum), 64'h0000_0001);
        check("hold_co", 64'(co), 64'd1);

        // start held through RUN with churning operands, then back-to-back.
        begin
            int busy_cnt;
            logic got;
            @(negedge clk);
            a = 32'h0102_0304; b = 32'h1020_3040; ci = 1'b0; start = 1'b1;
            sb_q.push_back({1'b0, 32'h1122_3344});
            busy_cnt = 0; got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    got = 1'b1;
                end else begin
                    if (busy === 1'b1) busy_cnt++;
                    a = $urandom; b = $urandom; ci = 1'($urandom);
                end
            end
            check("held_done_seen", 64'(got), 64'd1);
            check("held_busy_cycles", 64'(busy_cnt), 64'd4);
            a = 32'hDEAD_BEEF; b = 32'h2152_4111; ci = 1'b1;
            sb_q.push_back({1'b1, 32'h0000_0001});
            @(negedge clk);
            check("b2b_busy", 64'(busy), 64'd1);
            start = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                a = $urandom; b = $urandom;
                @(negedge clk);
                if (done === 1'b1) got = 1'b1;
            end
            check("b2b_done_seen", 64'(got), 64'd1);
        end

        // Reset in the middle of a run: nothing may complete.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; ci = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_co", 64'(co), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, "after_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequencer that performs NBYTES-wide addition by time-multiplexing one eight_bit_adder instance, one byte per clock, LSB byte first.
- Carry is chained between bytes through a register.
- Sits between a requester (start/operands) and the shared 8-bit adder datapath, giving wide adds without a wide combinational carry chain.

Parameters:
- NBYTES, 4, number of operand bytes (>=1); operand width = 8*NBYTES.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse/level; sampled only when the block is ready.
- a  input  8*NBYTES  operand A; latched on accepted start.
- b  input  8*NBYTES  operand B; latched on accepted start.
- ci  input  1  carry-in to byte 0; latched on accepted start.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle completion pulse.
- sum  output  8*NBYTES  result; updated only on the completion edge.
- co  output  1  final carry-out; updated only on the completion edge.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, co=0. Internal operand, carry, index and partial-result registers are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b, ci; idx<=0; carry_reg<=ci; ->RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Adder inputs are byte idx of latched a and b, with carry_reg as carry-in.
  - Each edge: write adder so into partial byte idx; carry_reg<=adder co; idx<=idx+1.
  - On the edge that processes byte NBYTES-1: sum<={final partial result}; co<=adder co; ->DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 at this edge: accepted exactly as in IDLE (back-to-back), ->RUN.
  - Otherwise ->IDLE.
- busy=1 in RUN only; busy=0 in IDLE and DONE.
- Ready (start accepted) = IDLE or DONE. start in RUN is ignored and not queued.
- Latency: with the start-sampling edge as edge 0, done is high in the cycle after edge NBYTES. Throughput is one add per NBYTES+1 cycles.
- Operand inputs may change freely after acceptance and have no effect on the result in progress.
- sum and co hold their last result until the next completion edge. They are never partially updated and never cleared except by reset.
- Arithmetic is unsigned modulo 2^(8*NBYTES); co is bit 8*NBYTES of a+b+ci.
- The carry propagates one byte per cycle through carry_reg, including a full ripple (e.g. all-ones + 1).
- idx width is clog2(NBYTES), minimum 1. idx never exceeds NBYTES-1.
- NBYTES=1: RUN lasts one edge. done appears in the cycle after edge 1.
- Reset mid-operation (rst_n low in any state):
  - Immediate, asynchronous return to IDLE with all outputs at reset values.
  - The in-flight result is discarded and done does not pulse.
  - The first start after reset release behaves normally.
- The block instantiates exactly one eight_bit_adder. No other adder logic is permitted.

Test Plan:
- Reset check: hold rst_n=0, drive random inputs and clocks -> busy=0, done=0, sum=0, co=0 throughout. Release -> still IDLE, all outputs 0.
- NBYTES=4, a=0x00000002, b=0x00000003, ci=0, start for 1 cycle:
  - busy=1 for 4 cycles.
  - done pulse in the cycle after edge 4.
  - sum=0x00000005, co=0.
- Full ripple: a=0xFFFFFFFF, b=0x00000001, ci=0 -> sum=0x00000000, co=1.
- Carry-in chaining:
  - a=0x000000FF, b=0x00000000, ci=1 -> sum=0x00000100, co=0.
  - Then a=0x80000000, b=0x80000000, ci=1 -> sum=0x00000001, co=1.
- start held high through RUN, with a/b changed every cycle during RUN:
  - Exactly one result, computed from the operands latched at acceptance.
  - A second start asserted in the DONE cycle is accepted back-to-back: busy=1 in the next cycle, second result correct.
- Reset mid-run: start 0x12345678+0x11111111, then pull rst_n low after edge 2 -> outputs to 0 immediately, no done pulse. After release, 0x00000010+0x00000020 -> sum=0x00000030, co=0.
